// File: rtl/timer_ctrl_pkg.sv
// Shared types and constants for the timer mode controller: FSM state
// encoding, mode select values and the default counter width.
package timer_ctrl_pkg;

    localparam int W_DEFAULT = 8;

    localparam logic MODE_STOPWATCH = 1'b0;
    localparam logic MODE_COUNTDOWN = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_e;

endpackage

// File: rtl/timer_mode_controller.sv
// Sequences an external up-counter for stopwatch/countdown timing: drives its
// reset/load/inc controls and reports running, done and a one-shot alarm.
module timer_mode_controller
    import timer_ctrl_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int SW_MAX = 99
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         tick,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         mode,
    input  logic [W-1:0] preset,
    input  logic [W-1:0] pc_value,
    output logic         pc_reset,
    output logic [W-1:0] pc_reset_val,
    output logic         pc_load,
    output logic [W-1:0] pc_load_val,
    output logic         pc_inc,
    output logic [W-1:0] time_value,
    output logic         running,
    output logic         done,
    output logic         alarm_pulse
);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   pc_reset_q, pc_reset_d;
    logic   pc_load_q, pc_load_d;
    logic   alarm_q, alarm_d;
    logic   terminal;
    logic   sel_mode;

    // Until IDLE is left the live mode input governs previews; after that the
    // captured mode is authoritative so mid-run toggles are harmless.
    assign sel_mode = (state_q == ST_IDLE) ? mode : mode_q;

    assign terminal = (mode_q == MODE_STOPWATCH) ? (pc_value == W'(SW_MAX))
                                                 : (pc_value == '1);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        pc_reset_d = 1'b0;
        if (clear) begin
            state_d    = ST_IDLE;
            pc_reset_d = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_d = ST_ARM;
                        mode_d  = mode;
                    end
                end
                ST_ARM:   state_d = ST_RUN;
                ST_RUN: begin
                    if (stop)          state_d = ST_PAUSE;
                    else if (terminal) state_d = ST_DONE;
                end
                ST_PAUSE: if (start && !stop) state_d = ST_RUN;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_IDLE;
            endcase
        end
        pc_load_d = (state_d == ST_ARM);
        alarm_d   = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_STOPWATCH;
            pc_reset_q <= 1'b1;
            pc_load_q  <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            pc_reset_q <= pc_reset_d;
            pc_load_q  <= pc_load_d;
            alarm_q    <= alarm_d;
        end
    end

    assign pc_reset     = pc_reset_q;
    assign pc_reset_val = '0;
    assign pc_load      = pc_load_q;
    // Counting up from ~preset to all-ones takes exactly preset increments.
    assign pc_load_val  = (sel_mode == MODE_COUNTDOWN) ? ~preset : '0;
    assign pc_inc       = (state_q == ST_RUN) && tick && !terminal && !stop && !clear;

    always_comb begin
        time_value = pc_value;
        if (sel_mode == MODE_COUNTDOWN) begin
            if (state_q == ST_IDLE || state_q == ST_ARM) time_value = preset;
            else                                         time_value = ~pc_value;
        end
    end

    assign running     = (state_q == ST_RUN);
    assign done        = (state_q == ST_DONE);
    assign alarm_pulse = alarm_q;

endmodule

// File: tb/tb_timer_mode_controller.sv
// Self-checking bench for timer_mode_controller with a behavioural program
// counter closing the loop; expected counts flow through a scoreboard queue.
module tb_timer_mode_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, mode = 1'b0;
    logic [7:0] preset = 8'd0;
    logic [7:0] pc_value = 8'd0;
    logic       pc_reset, pc_load, pc_inc, running, done, alarm_pulse;
    logic [7:0] pc_reset_val, pc_load_val, time_value;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    timer_mode_controller #(.W(8), .SW_MAX(99)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .stop(stop),
        .clear(clear), .mode(mode), .preset(preset), .pc_value(pc_value),
        .pc_reset(pc_reset), .pc_reset_val(pc_reset_val), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .pc_inc(pc_inc), .time_value(time_value),
        .running(running), .done(done), .alarm_pulse(alarm_pulse)
    );

    always #5 clk = ~clk;

    // Program counter the controller drives.
    always @(posedge clk) begin
        if (pc_reset)     pc_value <= pc_reset_val;
        else if (pc_load) pc_value <= pc_load_val;
        else if (pc_inc)  pc_value <= pc_value + 8'd1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) cyc();
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL rst_pc_reset got=%0d exp=1", pc_reset); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rst_pc_load got=%0d exp=0", pc_load); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got=%0d exp=0", running); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0d exp=0", done); end
        checks++; if (alarm_pulse !== 1'b0) begin errors++; $display("FAIL rst_alarm got=%0d exp=0", alarm_pulse); end
        checks++; if (pc_reset_val !== 8'd0) begin errors++; $display("FAIL rst_reset_val got=%0d exp=0", pc_reset_val); end
        checks++; if (pc_value !== 8'd0) begin errors++; $display("FAIL rst_pc_value got=%0d exp=0", pc_value); end
        reset_n = 1'b1;
        cyc();
        checks++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL rst_release_pc_reset got=%0d exp=0", pc_reset); end
        $display("test_reset done");
    endtask

    task automatic test_stopwatch_start();
        int e;
        mode = 1'b0; preset = 8'd37;
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL sw_arm_load got=%0d exp=1", pc_load); end
        checks++; if (pc_load_val !== 8'd0) begin errors++; $display("FAIL sw_load_val got=%0d exp=0", pc_load_val); end
        cyc();
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL sw_run_load got=%0d exp=0", pc_load); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL sw_running got=%0d exp=1", running); end
        checks++; if (pc_value !== 8'd0) begin errors++; $display("FAIL sw_loaded got=%0d exp=0", pc_value); end
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            exp_q.push_back(i + 1);
            cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL sw_tick got=%0d exp=%0d", pc_value, e); end
        end
        tick = 1'b0;
        checks++; if (time_value !== 8'd5) begin errors++; $display("FAIL sw_time got=%0d exp=5", time_value); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL sw_running5 got=%0d exp=1", running); end
        $display("test_stopwatch_start done");
    endtask

    task automatic test_stopwatch_done();
        int e;
        int model = 5;
        int alarm_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick = 1'b1;
            if (model < 99) model++;
            exp_q.push_back(model);
            cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL sw_count got=%0d exp=%0d", pc_value, e); end
            if (alarm_pulse === 1'b1) alarm_cnt++;
            if (pc_value == 8'd99) begin
                checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL sw_inc_at_max got=%0d exp=0", pc_inc); end
            end
        end
        tick = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sw_done got=%0d exp=1", done); end
        checks++; if (alarm_cnt != 1) begin errors++; $display("FAIL sw_alarm_cycles got=%0d exp=1", alarm_cnt); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL sw_done_running got=%0d exp=0", running); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_ignores_start got=%0d exp=1", done); end
        clear = 1'b1; cyc(); clear = 1'b0;
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL clr_pc_reset got=%0d exp=1", pc_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL clr_done got=%0d exp=0", done); end
        cyc();
        checks++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL clr_pulse_len got=%0d exp=0", pc_reset); end
        checks++; if (pc_value !== 8'd0) begin errors++; $display("FAIL clr_pc_value got=%0d exp=0", pc_value); end
        $display("test_stopwatch_done done");
    endtask

    task automatic test_countdown();
        int e;
        mode = 1'b1; preset = 8'd10;
        #1;
        checks++; if (time_value !== 8'd10) begin errors++; $display("FAIL cd_idle_time got=%0d exp=10", time_value); end
        checks++; if (pc_load_val !== 8'hF5) begin errors++; $display("FAIL cd_idle_load_val got=%0h exp=f5", pc_load_val); end
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (pc_load !== 1'b1) begin errors++; $display("FAIL cd_arm_load got=%0d exp=1", pc_load); end
        checks++; if (pc_load_val !== 8'hF5) begin errors++; $display("FAIL cd_arm_load_val got=%0h exp=f5", pc_load_val); end
        checks++; if (time_value !== 8'd10) begin errors++; $display("FAIL cd_arm_time got=%0d exp=10", time_value); end
        cyc();
        checks++; if (pc_value !== 8'hF5) begin errors++; $display("FAIL cd_loaded got=%0h exp=f5", pc_value); end
        checks++; if (time_value !== 8'd10) begin errors++; $display("FAIL cd_run_time got=%0d exp=10", time_value); end
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            exp_q.push_back(9 - i);
            cyc();
            e = exp_q.pop_front();
            checks++; if (time_value !== 8'(e)) begin errors++; $display("FAIL cd_time got=%0d exp=%0d", time_value, e); end
        end
        checks++; if (pc_value !== 8'hFF) begin errors++; $display("FAIL cd_final got=%0h exp=ff", pc_value); end
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL cd_inc_at_term got=%0d exp=0", pc_inc); end
        cyc();
        tick = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL cd_done got=%0d exp=1", done); end
        checks++; if (alarm_pulse !== 1'b1) begin errors++; $display("FAIL cd_alarm got=%0d exp=1", alarm_pulse); end
        checks++; if (pc_value !== 8'hFF) begin errors++; $display("FAIL cd_no_overshoot got=%0h exp=ff", pc_value); end
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        $display("test_countdown done");
    endtask

    task automatic test_pause();
        int e;
        mode = 1'b0;
        start = 1'b1; cyc(); start = 1'b0; cyc();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; exp_q.push_back(i + 1); cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL pause_pre got=%0d exp=%0d", pc_value, e); end
        end
        tick = 1'b0;
        stop = 1'b1; cyc(); stop = 1'b0;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_running got=%0d exp=0", running); end
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; exp_q.push_back(3); cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL pause_hold got=%0d exp=%0d", pc_value, e); end
        end
        tick = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got=%0d exp=1", running); end
        for (int i = 0; i < 2; i++) begin
            tick = 1'b1; exp_q.push_back(4 + i); cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL resume_count got=%0d exp=%0d", pc_value, e); end
        end
        tick = 1'b0;
        stop = 1'b1; clear = 1'b1; cyc(); stop = 1'b0; clear = 1'b0;
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL stopclr_pc_reset got=%0d exp=1", pc_reset); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL stopclr_running got=%0d exp=0", running); end
        cyc();
        checks++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL stopclr_pulse_len got=%0d exp=0", pc_reset); end
        checks++; if (pc_value !== 8'd0) begin errors++; $display("FAIL stopclr_pc_value got=%0d exp=0", pc_value); end
        $display("test_pause done");
    endtask

    task automatic test_preset_zero();
        mode = 1'b1; preset = 8'd0;
        start = 1'b1; cyc(); start = 1'b0;
        checks++; if (pc_load_val !== 8'hFF) begin errors++; $display("FAIL pz_load_val got=%0h exp=ff", pc_load_val); end
        tick = 1'b1;
        cyc();
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL pz_inc got=%0d exp=0", pc_inc); end
        cyc();
        tick = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL pz_done got=%0d exp=1", done); end
        checks++; if (alarm_pulse !== 1'b1) begin errors++; $display("FAIL pz_alarm got=%0d exp=1", alarm_pulse); end
        checks++; if (pc_value !== 8'hFF) begin errors++; $display("FAIL pz_pc_value got=%0h exp=ff", pc_value); end
        clear = 1'b1; cyc(); clear = 1'b0; cyc();
        $display("test_preset_zero done");
    endtask

    task automatic test_mode_toggle();
        int e;
        mode = 1'b0; preset = 8'd0;
        start = 1'b1; cyc(); start = 1'b0;
        mode = 1'b1;
        #1;
        checks++; if (pc_load_val !== 8'd0) begin errors++; $display("FAIL mt_arm_load_val got=%0h exp=0", pc_load_val); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; mode = ~mode; exp_q.push_back(i + 1); cyc();
            e = exp_q.pop_front();
            checks++; if (pc_value !== 8'(e)) begin errors++; $display("FAIL mt_count got=%0d exp=%0d", pc_value, e); end
        end
        tick = 1'b0;
        checks++; if (time_value !== 8'd3) begin errors++; $display("FAIL mt_time got=%0d exp=3", time_value); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL mt_running got=%0d exp=1", running); end
        $display("test_mode_toggle done");
    endtask

    task automatic test_async_reset();
        tick = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL ar_running got=%0d exp=0", running); end
        checks++; if (pc_reset !== 1'b1) begin errors++; $display("FAIL ar_pc_reset got=%0d exp=1", pc_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL ar_done got=%0d exp=0", done); end
        checks++; if (alarm_pulse !== 1'b0) begin errors++; $display("FAIL ar_alarm got=%0d exp=0", alarm_pulse); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ar_load got=%0d exp=0", pc_load); end
        checks++; if (pc_inc !== 1'b0) begin errors++; $display("FAIL ar_inc got=%0d exp=0", pc_inc); end
        tick = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        checks++; if (pc_value !== 8'd0) begin errors++; $display("FAIL ar_pc_value got=%0d exp=0", pc_value); end
        checks++; if (pc_reset !== 1'b0) begin errors++; $display("FAIL ar_release got=%0d exp=0", pc_reset); end
        $display("test_async_reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stopwatch_start();
        test_stopwatch_done();
        test_countdown();
        test_pause();
        test_preset_zero();
        test_mode_toggle();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
